joueur_ctrl: RTL and testbench

Player controller producing the position and sprite selection that the player sprite renderer consumes (`centerX`, `centerY`, `sprite_num`). Once per video frame it samples the direction buttons and computes a one-step move clamped to the playfield. It asks the map checker whether the target cell is free over a valid/response handshake, then commits the move and advances the walk animation. All updates happen during vertical blanking, so the renderer never sees a position change mid-frame.

---
 rtl/bomberman_pkg.sv | 35 +++
 rtl/joueur_anim.sv | 35 +++
 rtl/joueur_ctrl.sv | 164 ++++++++++++++++
 tb/tb_joueur_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// rtl/bomberman_pkg.sv - shared types and constants for the bomberman video blocks
package bomberman_pkg;

    localparam int HACTIVE     = 800;
    localparam int VACTIVE     = 600;
    localparam int SPRITE_SIZE = 32;
    localparam int COORD_W     = 11;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        REQ    = 2'd2
    } ctrl_state_t;

    // Saturate a coordinate into an inclusive [lo, hi] window (signed compare).
    function automatic coord_t clamp_coord(input coord_t v, input coord_t lo, input coord_t hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/joueur_anim.sv
// rtl/joueur_anim.sv - walk animation divider and 2-bit frame counter
module joueur_anim #(
    parameter int ANIM_DIV = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       advance,
    output logic [1:0] frame
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

    logic [CNT_W-1:0] anim_cnt;

    // Count committed moves; every ANIM_DIV-th move steps the walk frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            anim_cnt <= '0;
            frame    <= 2'd0;
        end else if (clear) begin
            anim_cnt <= '0;
            frame    <= 2'd0;
        end else if (advance) begin
            if (anim_cnt == CNT_LAST) begin
                anim_cnt <= '0;
                frame    <= frame + 2'd1;
            end else begin
                anim_cnt <= anim_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/joueur_ctrl.sv
// rtl/joueur_ctrl.sv - per-frame player move with map query handshake
module joueur_ctrl
    import bomberman_pkg::*;
#(
    parameter int START_X  = SPRITE_SIZE,
    parameter int START_Y  = SPRITE_SIZE,
    parameter int STEP     = 2,
    parameter int ANIM_DIV = 8,
    parameter int X_MIN    = SPRITE_SIZE,
    parameter int X_MAX    = HACTIVE - 2 * SPRITE_SIZE,
    parameter int Y_MIN    = SPRITE_SIZE,
    parameter int Y_MAX    = VACTIVE - 2 * SPRITE_SIZE
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                frame_tick,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    output logic                req_valid,
    output logic signed [10:0]  req_x,
    output logic signed [10:0]  req_y,
    input  logic                resp_valid,
    input  logic                resp_free,
    output logic signed [10:0]  centerX,
    output logic signed [10:0]  centerY,
    output logic [3:0]          sprite_num
);

    localparam coord_t START_X_C = coord_t'(START_X);
    localparam coord_t START_Y_C = coord_t'(START_Y);
    localparam coord_t STEP_C    = coord_t'(STEP);
    localparam coord_t X_MIN_C   = coord_t'(X_MIN);
    localparam coord_t X_MAX_C   = coord_t'(X_MAX);
    localparam coord_t Y_MIN_C   = coord_t'(Y_MIN);
    localparam coord_t Y_MAX_C   = coord_t'(Y_MAX);

    ctrl_state_t state_q, state_d;
    dir_t        dir_q, sel_dir;
    coord_t      tgt_x, tgt_y;
    logic        btn_any, moved;
    logic        load_req, drop_req, commit, dir_load;
    logic        anim_clear, anim_adv;
    logic [1:0]  frame;

    assign btn_any    = btn_up | btn_down | btn_left | btn_right;
    assign moved      = (tgt_x != centerX) || (tgt_y != centerY);
    assign sprite_num = {dir_q, frame};

    // Button priority up > down > left > right, one clamped step on one axis.
    always_comb begin
        sel_dir = RIGHT;
        tgt_x   = centerX;
        tgt_y   = centerY;
        if (btn_up) begin
            sel_dir = UP;
            tgt_y   = clamp_coord(centerY - STEP_C, Y_MIN_C, Y_MAX_C);
        end else if (btn_down) begin
            sel_dir = DOWN;
            tgt_y   = clamp_coord(centerY + STEP_C, Y_MIN_C, Y_MAX_C);
        end else if (btn_left) begin
            sel_dir = LEFT;
            tgt_x   = clamp_coord(centerX - STEP_C, X_MIN_C, X_MAX_C);
        end else if (btn_right) begin
            sel_dir = RIGHT;
            tgt_x   = clamp_coord(centerX + STEP_C, X_MIN_C, X_MAX_C);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes; ticks outside IDLE are dropped.
    always_comb begin
        state_d    = state_q;
        load_req   = 1'b0;
        drop_req   = 1'b0;
        commit     = 1'b0;
        dir_load   = 1'b0;
        anim_clear = 1'b0;
        anim_adv   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                state_d = IDLE;
                if (!btn_any) begin
                    anim_clear = 1'b1;
                end else begin
                    dir_load = 1'b1;
                    if (!moved) begin
                        anim_clear = 1'b1;
                    end else begin
                        load_req = 1'b1;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                if (resp_valid) begin
                    state_d  = IDLE;
                    drop_req = 1'b1;
                    if (resp_free) begin
                        commit   = 1'b1;
                        anim_adv = 1'b1;
                    end else begin
                        anim_clear = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Query registers, committed position and facing direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_valid <= 1'b0;
            req_x     <= START_X_C;
            req_y     <= START_Y_C;
            centerX   <= START_X_C;
            centerY   <= START_Y_C;
            dir_q     <= DOWN;
        end else begin
            if (dir_load) begin
                dir_q <= sel_dir;
            end
            if (load_req) begin
                req_valid <= 1'b1;
                req_x     <= tgt_x;
                req_y     <= tgt_y;
            end else if (drop_req) begin
                req_valid <= 1'b0;
            end
            if (commit) begin
                centerX <= req_x;
                centerY <= req_y;
            end
        end
    end

    joueur_anim #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (anim_clear),
        .advance (anim_adv),
        .frame   (frame)
    );

endmodule

// File: tb/tb_joueur_ctrl.sv
// tb/tb_joueur_ctrl.sv - scoreboard bench for joueur_ctrl
module tb_joueur_ctrl;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               frame_tick;
    logic               btn_up, btn_down, btn_left, btn_right;
    logic               req_valid;
    logic signed [10:0] req_x, req_y;
    logic               resp_valid, resp_free;
    logic signed [10:0] centerX, centerY;
    logic [3:0]         sprite_num;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit req;
        int rx;
        int ry;
        int cx;
        int cy;
        int spr2;
        int sprf;
    } exp_t;

    exp_t exp_q[$];

    int mx, my, mdir, mframe, manim;

    always #5 clk = ~clk;

    joueur_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_free  (resp_free),
        .centerX    (centerX),
        .centerY    (centerY),
        .sprite_num (sprite_num)
    );

    task automatic check_eq(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        mx = 32; my = 32; mdir = 0; mframe = 0; manim = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_cx"}, int'(centerX), 32);
        check_eq({tag, "_cy"}, int'(centerY), 32);
        check_eq({tag, "_spr"}, int'(sprite_num), 0);
        check_eq({tag, "_rv"}, int'(req_valid), 0);
        check_eq({tag, "_rx"}, int'(req_x), 32);
        check_eq({tag, "_ry"}, int'(req_y), 32);
    endtask

    // Model one frame, push its expectations, then drive it and score.
    task automatic do_frame(input bit u, input bit d, input bit l, input bit r,
                            input int k, input bit free, input string tag);
        exp_t e;
        int   tx, ty;
        tx = mx;
        ty = my;
        if (u | d | l | r) begin
            if (u)      begin mdir = 1; ty = my - 2; end
            else if (d) begin mdir = 0; ty = my + 2; end
            else if (l) begin mdir = 2; tx = mx - 2; end
            else        begin mdir = 3; tx = mx + 2; end
            if (tx < 32) tx = 32;
            if (tx > 736) tx = 736;
            if (ty < 32) ty = 32;
            if (ty > 536) ty = 536;
        end
        e.req = (u | d | l | r) && (tx != mx || ty != my);
        e.rx  = tx;
        e.ry  = ty;
        if (!e.req) begin
            mframe = 0;
            manim  = 0;
        end
        e.spr2 = mdir * 4 + mframe;
        if (e.req) begin
            if (free) begin
                mx = tx;
                my = ty;
                if (manim == 7) begin
                    manim  = 0;
                    mframe = (mframe + 1) % 4;
                end else begin
                    manim++;
                end
            end else begin
                mframe = 0;
                manim  = 0;
            end
        end
        e.cx   = mx;
        e.cy   = my;
        e.sprf = mdir * 4 + mframe;
        exp_q.push_back(e);

        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq({tag, "_rv_t2"}, int'(req_valid), int'(e.req));
        check_eq({tag, "_dir_t2"}, int'(sprite_num[3:2]), e.spr2 / 4);
        if (e.req) begin
            check_eq({tag, "_rx_t2"}, int'(req_x), e.rx);
            check_eq({tag, "_ry_t2"}, int'(req_y), e.ry);
            resp_free = free;
            for (int i = 0; i < k; i++) begin
                @(negedge clk);
                check_eq({tag, "_rv_hold"}, int'(req_valid), 1);
                check_eq({tag, "_rx_hold"}, int'(req_x), e.rx);
                check_eq({tag, "_ry_hold"}, int'(req_y), e.ry);
            end
            resp_valid = 1'b1;
            @(negedge clk);
            resp_valid = 1'b0;
            resp_free  = 1'b0;
        end
        check_eq({tag, "_rv_end"}, int'(req_valid), 0);
        check_eq({tag, "_cx"}, int'(centerX), e.cx);
        check_eq({tag, "_cy"}, int'(centerY), e.cy);
        check_eq({tag, "_spr"}, int'(sprite_num), e.sprf);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        resp_valid = 1'b0;
        resp_free  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) do_frame(0, 0, 0, 0, 0, 1, "idle");
        do_frame(0, 0, 1, 0, 0, 1, "left_edge");
        for (int i = 0; i < 8; i++) do_frame(0, 0, 0, 1, 0, 1, "right");
        check_eq("right8_cx", int'(centerX), 48);
        check_eq("right8_spr", int'(sprite_num), 13);
        do_frame(0, 1, 0, 0, 2, 1, "down");
        do_frame(1, 0, 0, 0, 5, 0, "up_blocked");
        do_frame(1, 0, 0, 1, 1, 1, "up_right");
        for (int i = 0; i < 8; i++) begin
            do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
        end

        // Extra tick while a query is pending, then reset before the answer.
        @(negedge clk);
        btn_down   = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        check_eq("mid_rv", int'(req_valid), 1);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check_eq("tick_in_req_rv", int'(req_valid), 1);
        @(negedge clk);
        check_eq("tick_in_req_rv2", int'(req_valid), 1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_rst");
        @(negedge clk);
        reset_n   = 1'b1;
        btn_down  = 1'b0;
        resp_free = 1'b1;
        resp_valid = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_free  = 1'b0;
        @(negedge clk);
        check_reset_values("late_resp");
        do_frame(0, 0, 0, 1, 0, 1, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
